// File: rtl/user_pkg.sv
// Shared types, opcodes and CSR offsets for the slot-0 user logic.
package user_pkg;

  localparam int unsigned REQ_BITS      = 128;
  localparam int unsigned ACK_BITS      = 32;
  localparam int unsigned NOT_BITS      = 38;
  localparam int unsigned CSR_DATA_BITS = 64;
  localparam int unsigned CSR_STRB_BITS = CSR_DATA_BITS / 8;
  localparam int unsigned VADDR_BITS    = 48;
  localparam int unsigned LEN_BITS      = 28;
  localparam int unsigned PID_W         = 6;
  localparam int unsigned CNT_BITS      = 32;
  localparam int unsigned LANE_BITS     = 32;

  localparam logic [4:0] OP_RD     = 5'd1;
  localparam logic [4:0] OP_WR     = 5'd2;
  localparam logic [1:0] STRM_HOST = 2'd1;

  localparam logic [7:0] CSR_CTRL     = 8'h00;
  localparam logic [7:0] CSR_STATUS   = 8'h08;
  localparam logic [7:0] CSR_RD_VADDR = 8'h10;
  localparam logic [7:0] CSR_WR_VADDR = 8'h18;
  localparam logic [7:0] CSR_LEN      = 8'h20;
  localparam logic [7:0] CSR_DONE_CNT = 8'h28;
  localparam logic [7:0] CSR_INCR     = 8'h30;
  localparam logic [7:0] CSR_PID      = 8'h38;

  typedef struct packed {
    logic [33:0] rsvd;
    logic [4:0]  opcode;
    logic [1:0]  strm;
    logic        last;
    logic [3:0]  dest;
    logic [5:0]  pid;
    logic [47:0] vaddr;
    logic [27:0] len;
  } req_t;

  typedef struct packed {
    logic [4:0]  opcode;
    logic [5:0]  pid;
    logic [3:0]  dest;
    logic [1:0]  strm;
    logic [14:0] rsvd;
  } ack_t;

  typedef struct packed {
    logic [5:0]  pid;
    logic [31:0] value;
  } irq_not_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_CQ,
    ST_NOTIFY
  } state_e;

  // Byte-wise merge of a CSR write into the previous register value.
  function automatic logic [CSR_DATA_BITS-1:0] strb_merge(
    input logic [CSR_DATA_BITS-1:0] old_val,
    input logic [CSR_DATA_BITS-1:0] wdata,
    input logic [CSR_STRB_BITS-1:0] strb
  );
    logic [CSR_DATA_BITS-1:0] res;
    res = old_val;
    for (int unsigned b = 0; b < CSR_STRB_BITS; b++) begin
      if (strb[b]) res[b*8 +: 8] = wdata[b*8 +: 8];
    end
    return res;
  endfunction

  function automatic req_t build_req(
    input logic [4:0]  opcode,
    input logic [47:0] vaddr,
    input logic [27:0] len,
    input logic [5:0]  pid
  );
    req_t r;
    r        = '0;
    r.opcode = opcode;
    r.strm   = STRM_HOST;
    r.last   = 1'b1;
    r.dest   = 4'd0;
    r.pid    = pid;
    r.vaddr  = vaddr;
    r.len    = len;
    return r;
  endfunction

endpackage

// File: rtl/user_csr_slave.sv
// AXI4-Lite slave and CSR file; job status and completion count come from the FSM.
module user_csr_slave
  import user_pkg::*;
#(
  parameter int unsigned ADDR_BITS = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDR_BITS-1:0]     awaddr_i,
  input  logic                     awvalid_i,
  output logic                     awready_o,
  input  logic [CSR_DATA_BITS-1:0] wdata_i,
  input  logic [CSR_STRB_BITS-1:0] wstrb_i,
  input  logic                     wvalid_i,
  output logic                     wready_o,
  output logic [1:0]               bresp_o,
  output logic                     bvalid_o,
  input  logic                     bready_i,
  input  logic [ADDR_BITS-1:0]     araddr_i,
  input  logic                     arvalid_i,
  output logic                     arready_o,
  output logic [CSR_DATA_BITS-1:0] rdata_o,
  output logic [1:0]               rresp_o,
  output logic                     rvalid_o,
  input  logic                     rready_i,
  input  logic                     busy_i,
  input  logic                     done_i,
  input  logic [CNT_BITS-1:0]      done_cnt_i,
  output logic                     start_o,
  output logic [VADDR_BITS-1:0]    rd_vaddr_o,
  output logic [VADDR_BITS-1:0]    wr_vaddr_o,
  output logic [LEN_BITS-1:0]      len_o,
  output logic [LANE_BITS-1:0]     incr_o,
  output logic [PID_W-1:0]         pid_o
);

  logic                     bvalid_q;
  logic                     rvalid_q;
  logic [CSR_DATA_BITS-1:0] rdata_q;
  logic [CSR_DATA_BITS-1:0] rdata_c;
  logic                     start_q;
  logic [VADDR_BITS-1:0]    rd_vaddr_q;
  logic [VADDR_BITS-1:0]    wr_vaddr_q;
  logic [LEN_BITS-1:0]      len_q;
  logic [LANE_BITS-1:0]     incr_q;
  logic [PID_W-1:0]         pid_q;
  logic                     wr_fire;
  logic                     rd_fire;

  // One outstanding write and one outstanding read at a time.
  assign wr_fire = awvalid_i & wvalid_i & ~bvalid_q;
  assign rd_fire = arvalid_i & ~rvalid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      bvalid_q   <= 1'b0;
      start_q    <= 1'b0;
      rd_vaddr_q <= '0;
      wr_vaddr_q <= '0;
      len_q      <= '0;
      incr_q     <= '0;
      pid_q      <= '0;
    end else begin
      start_q <= 1'b0;
      if (wr_fire) begin
        bvalid_q <= 1'b1;
        case (awaddr_i)
          ADDR_BITS'(CSR_CTRL):     start_q    <= wstrb_i[0] & wdata_i[0];
          ADDR_BITS'(CSR_RD_VADDR): rd_vaddr_q <= VADDR_BITS'(strb_merge(CSR_DATA_BITS'(rd_vaddr_q), wdata_i, wstrb_i));
          ADDR_BITS'(CSR_WR_VADDR): wr_vaddr_q <= VADDR_BITS'(strb_merge(CSR_DATA_BITS'(wr_vaddr_q), wdata_i, wstrb_i));
          ADDR_BITS'(CSR_LEN):      len_q      <= LEN_BITS'(strb_merge(CSR_DATA_BITS'(len_q), wdata_i, wstrb_i));
          ADDR_BITS'(CSR_INCR):     incr_q     <= LANE_BITS'(strb_merge(CSR_DATA_BITS'(incr_q), wdata_i, wstrb_i));
          ADDR_BITS'(CSR_PID):      pid_q      <= PID_W'(strb_merge(CSR_DATA_BITS'(pid_q), wdata_i, wstrb_i));
          default: ;
        endcase
      end else if (bvalid_q && bready_i) begin
        bvalid_q <= 1'b0;
      end
    end
  end

  always_comb begin
    rdata_c = '0;
    case (araddr_i)
      ADDR_BITS'(CSR_STATUS):   rdata_c = CSR_DATA_BITS'({done_i, busy_i});
      ADDR_BITS'(CSR_RD_VADDR): rdata_c = CSR_DATA_BITS'(rd_vaddr_q);
      ADDR_BITS'(CSR_WR_VADDR): rdata_c = CSR_DATA_BITS'(wr_vaddr_q);
      ADDR_BITS'(CSR_LEN):      rdata_c = CSR_DATA_BITS'(len_q);
      ADDR_BITS'(CSR_DONE_CNT): rdata_c = CSR_DATA_BITS'(done_cnt_i);
      ADDR_BITS'(CSR_INCR):     rdata_c = CSR_DATA_BITS'(incr_q);
      ADDR_BITS'(CSR_PID):      rdata_c = CSR_DATA_BITS'(pid_q);
      default:                  rdata_c = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else if (rd_fire) begin
      rvalid_q <= 1'b1;
      rdata_q  <= rdata_c;
    end else if (rvalid_q && rready_i) begin
      rvalid_q <= 1'b0;
    end
  end

  assign awready_o  = ~bvalid_q;
  assign wready_o   = ~bvalid_q;
  assign bvalid_o   = bvalid_q;
  assign bresp_o    = 2'b00;
  assign arready_o  = ~rvalid_q;
  assign rvalid_o   = rvalid_q;
  assign rdata_o    = rdata_q;
  assign rresp_o    = 2'b00;
  assign start_o    = start_q;
  assign rd_vaddr_o = rd_vaddr_q;
  assign wr_vaddr_o = wr_vaddr_q;
  assign len_o      = len_q;
  assign incr_o     = incr_q;
  assign pid_o      = pid_q;

endmodule

// File: rtl/user_logic_c0.sv
// vFPGA slot-0 user logic: CSR-driven read/write job FSM plus a lane-adding host stream loopback.
module user_logic_c0
  import user_pkg::*;
#(
  parameter int unsigned AXIL_ADDR_BITS = 16,
  parameter int unsigned AXIL_DATA_BITS = 64,
  parameter int unsigned AXI_DATA_BITS  = 512,
  parameter int unsigned PID_BITS       = 6
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic [AXIL_ADDR_BITS-1:0]   s_axil_awaddr,
  input  logic                        s_axil_awvalid,
  output logic                        s_axil_awready,
  input  logic [AXIL_DATA_BITS-1:0]   s_axil_wdata,
  input  logic [AXIL_DATA_BITS/8-1:0] s_axil_wstrb,
  input  logic                        s_axil_wvalid,
  output logic                        s_axil_wready,
  output logic [1:0]                  s_axil_bresp,
  output logic                        s_axil_bvalid,
  input  logic                        s_axil_bready,
  input  logic [AXIL_ADDR_BITS-1:0]   s_axil_araddr,
  input  logic                        s_axil_arvalid,
  output logic                        s_axil_arready,
  output logic [AXIL_DATA_BITS-1:0]   s_axil_rdata,
  output logic [1:0]                  s_axil_rresp,
  output logic                        s_axil_rvalid,
  input  logic                        s_axil_rready,
  output logic [REQ_BITS-1:0]         sq_rd_data,
  output logic                        sq_rd_valid,
  input  logic                        sq_rd_ready,
  output logic [REQ_BITS-1:0]         sq_wr_data,
  output logic                        sq_wr_valid,
  input  logic                        sq_wr_ready,
  input  logic [ACK_BITS-1:0]         cq_rd_data,
  input  logic                        cq_rd_valid,
  output logic                        cq_rd_ready,
  input  logic [ACK_BITS-1:0]         cq_wr_data,
  input  logic                        cq_wr_valid,
  output logic                        cq_wr_ready,
  output logic [NOT_BITS-1:0]         notify_data,
  output logic                        notify_valid,
  input  logic                        notify_ready,
  input  logic [AXI_DATA_BITS-1:0]    axis_host_recv_tdata,
  input  logic [AXI_DATA_BITS/8-1:0]  axis_host_recv_tkeep,
  input  logic                        axis_host_recv_tlast,
  input  logic [PID_BITS-1:0]         axis_host_recv_tid,
  input  logic                        axis_host_recv_tvalid,
  output logic                        axis_host_recv_tready,
  output logic [AXI_DATA_BITS-1:0]    axis_host_send_tdata,
  output logic [AXI_DATA_BITS/8-1:0]  axis_host_send_tkeep,
  output logic                        axis_host_send_tlast,
  output logic [PID_BITS-1:0]         axis_host_send_tid,
  output logic                        axis_host_send_tvalid,
  input  logic                        axis_host_send_tready
);

  localparam int unsigned LANES = AXI_DATA_BITS / LANE_BITS;

  logic                  csr_start;
  logic [VADDR_BITS-1:0] csr_rd_vaddr;
  logic [VADDR_BITS-1:0] csr_wr_vaddr;
  logic [LEN_BITS-1:0]   csr_len;
  logic [LANE_BITS-1:0]  csr_incr;
  logic [PID_W-1:0]      csr_pid;

  state_e                state_q, state_d;
  logic                  sq_rd_vld_q, sq_rd_vld_d;
  logic                  sq_wr_vld_q, sq_wr_vld_d;
  req_t                  rd_req_q, rd_req_d;
  req_t                  wr_req_q, wr_req_d;
  logic                  rd_ack_q, rd_ack_d;
  logic                  wr_ack_q, wr_ack_d;
  logic                  cq_rdy_q, cq_rdy_d;
  logic                  not_vld_q, not_vld_d;
  irq_not_t              not_data_q, not_data_d;
  logic                  done_q, done_d;
  logic [CNT_BITS-1:0]   done_cnt_q, done_cnt_d;
  logic                  busy;

  // Completion payloads carry nothing the job needs beyond the handshake.
  logic unused_ack;
  assign unused_ack = ^{cq_rd_data, cq_wr_data};

  assign busy = (state_q != ST_IDLE);

  user_csr_slave #(
    .ADDR_BITS (AXIL_ADDR_BITS)
  ) u_csr (
    .clk        (aclk),
    .rst        (areset),
    .awaddr_i   (s_axil_awaddr),
    .awvalid_i  (s_axil_awvalid),
    .awready_o  (s_axil_awready),
    .wdata_i    (s_axil_wdata),
    .wstrb_i    (s_axil_wstrb),
    .wvalid_i   (s_axil_wvalid),
    .wready_o   (s_axil_wready),
    .bresp_o    (s_axil_bresp),
    .bvalid_o   (s_axil_bvalid),
    .bready_i   (s_axil_bready),
    .araddr_i   (s_axil_araddr),
    .arvalid_i  (s_axil_arvalid),
    .arready_o  (s_axil_arready),
    .rdata_o    (s_axil_rdata),
    .rresp_o    (s_axil_rresp),
    .rvalid_o   (s_axil_rvalid),
    .rready_i   (s_axil_rready),
    .busy_i     (busy),
    .done_i     (done_q),
    .done_cnt_i (done_cnt_q),
    .start_o    (csr_start),
    .rd_vaddr_o (csr_rd_vaddr),
    .wr_vaddr_o (csr_wr_vaddr),
    .len_o      (csr_len),
    .incr_o     (csr_incr),
    .pid_o      (csr_pid)
  );

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q     <= ST_IDLE;
      sq_rd_vld_q <= 1'b0;
      sq_wr_vld_q <= 1'b0;
      rd_req_q    <= '0;
      wr_req_q    <= '0;
      rd_ack_q    <= 1'b0;
      wr_ack_q    <= 1'b0;
      cq_rdy_q    <= 1'b0;
      not_vld_q   <= 1'b0;
      not_data_q  <= '0;
      done_q      <= 1'b0;
      done_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      sq_rd_vld_q <= sq_rd_vld_d;
      sq_wr_vld_q <= sq_wr_vld_d;
      rd_req_q    <= rd_req_d;
      wr_req_q    <= wr_req_d;
      rd_ack_q    <= rd_ack_d;
      wr_ack_q    <= wr_ack_d;
      cq_rdy_q    <= cq_rdy_d;
      not_vld_q   <= not_vld_d;
      not_data_q  <= not_data_d;
      done_q      <= done_d;
      done_cnt_q  <= done_cnt_d;
    end
  end

  // Descriptors are latched at START so they stay stable while stalled.
  always_comb begin
    state_d     = state_q;
    sq_rd_vld_d = sq_rd_vld_q;
    sq_wr_vld_d = sq_wr_vld_q;
    rd_req_d    = rd_req_q;
    wr_req_d    = wr_req_q;
    rd_ack_d    = rd_ack_q;
    wr_ack_d    = wr_ack_q;
    cq_rdy_d    = cq_rdy_q;
    not_vld_d   = not_vld_q;
    not_data_d  = not_data_q;
    done_d      = done_q;
    done_cnt_d  = done_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (csr_start) begin
          state_d     = ST_ISSUE;
          sq_rd_vld_d = 1'b1;
          sq_wr_vld_d = 1'b1;
          rd_req_d    = build_req(OP_RD, csr_rd_vaddr, csr_len, csr_pid);
          wr_req_d    = build_req(OP_WR, csr_wr_vaddr, csr_len, csr_pid);
          done_d      = 1'b0;
        end
      end
      ST_ISSUE: begin
        if (sq_rd_vld_q && sq_rd_ready) sq_rd_vld_d = 1'b0;
        if (sq_wr_vld_q && sq_wr_ready) sq_wr_vld_d = 1'b0;
        if (!sq_rd_vld_d && !sq_wr_vld_d) begin
          state_d  = ST_WAIT_CQ;
          cq_rdy_d = 1'b1;
          rd_ack_d = 1'b0;
          wr_ack_d = 1'b0;
        end
      end
      ST_WAIT_CQ: begin
        rd_ack_d = rd_ack_q | (cq_rd_valid & cq_rdy_q);
        wr_ack_d = wr_ack_q | (cq_wr_valid & cq_rdy_q);
        if (rd_ack_d && wr_ack_d) begin
          state_d          = ST_NOTIFY;
          cq_rdy_d         = 1'b0;
          rd_ack_d         = 1'b0;
          wr_ack_d         = 1'b0;
          not_vld_d        = 1'b1;
          not_data_d.pid   = csr_pid;
          not_data_d.value = done_cnt_q + CNT_BITS'(1);
        end
      end
      ST_NOTIFY: begin
        if (notify_ready) begin
          state_d    = ST_IDLE;
          not_vld_d  = 1'b0;
          done_cnt_d = done_cnt_q + CNT_BITS'(1);
          done_d     = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign sq_rd_data   = rd_req_q;
  assign sq_rd_valid  = sq_rd_vld_q;
  assign sq_wr_data   = wr_req_q;
  assign sq_wr_valid  = sq_wr_vld_q;
  assign cq_rd_ready  = cq_rdy_q;
  assign cq_wr_ready  = cq_rdy_q;
  assign notify_data  = not_data_q;
  assign notify_valid = not_vld_q;

  logic [AXI_DATA_BITS-1:0]   s_data_q;
  logic [AXI_DATA_BITS/8-1:0] s_keep_q;
  logic                       s_last_q;
  logic [PID_BITS-1:0]        s_id_q;
  logic                       s_vld_q;
  logic [AXI_DATA_BITS-1:0]   lanes_c;
  logic                       recv_rdy_c;

  always_comb begin
    lanes_c = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      lanes_c[l*LANE_BITS +: LANE_BITS] = axis_host_recv_tdata[l*LANE_BITS +: LANE_BITS] + csr_incr;
    end
  end

  assign recv_rdy_c = ~s_vld_q | axis_host_send_tready;

  // Single skid-free pipeline stage: refills in the same cycle it drains.
  always_ff @(posedge aclk) begin
    if (areset) begin
      s_vld_q  <= 1'b0;
      s_data_q <= '0;
      s_keep_q <= '0;
      s_last_q <= 1'b0;
      s_id_q   <= '0;
    end else if (axis_host_recv_tvalid && recv_rdy_c) begin
      s_vld_q  <= 1'b1;
      s_data_q <= lanes_c;
      s_keep_q <= axis_host_recv_tkeep;
      s_last_q <= axis_host_recv_tlast;
      s_id_q   <= axis_host_recv_tid;
    end else if (axis_host_send_tready) begin
      s_vld_q  <= 1'b0;
    end
  end

  assign axis_host_recv_tready = recv_rdy_c;
  assign axis_host_send_tdata  = s_data_q;
  assign axis_host_send_tkeep  = s_keep_q;
  assign axis_host_send_tlast  = s_last_q;
  assign axis_host_send_tid    = s_id_q;
  assign axis_host_send_tvalid = s_vld_q;

endmodule

// File: tb/tb_user_logic_c0.sv
// Directed self-checking bench for user_logic_c0: CSR access, job FSM, stream path, reset.
module tb_user_logic_c0;
  import user_pkg::*;

  logic         aclk;
  logic         areset;
  logic [15:0]  s_axil_awaddr;
  logic         s_axil_awvalid;
  logic         s_axil_awready;
  logic [63:0]  s_axil_wdata;
  logic [7:0]   s_axil_wstrb;
  logic         s_axil_wvalid;
  logic         s_axil_wready;
  logic [1:0]   s_axil_bresp;
  logic         s_axil_bvalid;
  logic         s_axil_bready;
  logic [15:0]  s_axil_araddr;
  logic         s_axil_arvalid;
  logic         s_axil_arready;
  logic [63:0]  s_axil_rdata;
  logic [1:0]   s_axil_rresp;
  logic         s_axil_rvalid;
  logic         s_axil_rready;
  logic [127:0] sq_rd_data;
  logic         sq_rd_valid;
  logic         sq_rd_ready;
  logic [127:0] sq_wr_data;
  logic         sq_wr_valid;
  logic         sq_wr_ready;
  logic [31:0]  cq_rd_data;
  logic         cq_rd_valid;
  logic         cq_rd_ready;
  logic [31:0]  cq_wr_data;
  logic         cq_wr_valid;
  logic         cq_wr_ready;
  logic [37:0]  notify_data;
  logic         notify_valid;
  logic         notify_ready;
  logic [511:0] recv_tdata;
  logic [63:0]  recv_tkeep;
  logic         recv_tlast;
  logic [5:0]   recv_tid;
  logic         recv_tvalid;
  logic         recv_tready;
  logic [511:0] send_tdata;
  logic [63:0]  send_tkeep;
  logic         send_tlast;
  logic [5:0]   send_tid;
  logic         send_tvalid;
  logic         send_tready;

  int unsigned n_assert;
  int unsigned n_fail;

  user_logic_c0 dut (
    .aclk                  (aclk),
    .areset                (areset),
    .s_axil_awaddr         (s_axil_awaddr),
    .s_axil_awvalid        (s_axil_awvalid),
    .s_axil_awready        (s_axil_awready),
    .s_axil_wdata          (s_axil_wdata),
    .s_axil_wstrb          (s_axil_wstrb),
    .s_axil_wvalid         (s_axil_wvalid),
    .s_axil_wready         (s_axil_wready),
    .s_axil_bresp          (s_axil_bresp),
    .s_axil_bvalid         (s_axil_bvalid),
    .s_axil_bready         (s_axil_bready),
    .s_axil_araddr         (s_axil_araddr),
    .s_axil_arvalid        (s_axil_arvalid),
    .s_axil_arready        (s_axil_arready),
    .s_axil_rdata          (s_axil_rdata),
    .s_axil_rresp          (s_axil_rresp),
    .s_axil_rvalid         (s_axil_rvalid),
    .s_axil_rready         (s_axil_rready),
    .sq_rd_data            (sq_rd_data),
    .sq_rd_valid           (sq_rd_valid),
    .sq_rd_ready           (sq_rd_ready),
    .sq_wr_data            (sq_wr_data),
    .sq_wr_valid           (sq_wr_valid),
    .sq_wr_ready           (sq_wr_ready),
    .cq_rd_data            (cq_rd_data),
    .cq_rd_valid           (cq_rd_valid),
    .cq_rd_ready           (cq_rd_ready),
    .cq_wr_data            (cq_wr_data),
    .cq_wr_valid           (cq_wr_valid),
    .cq_wr_ready           (cq_wr_ready),
    .notify_data           (notify_data),
    .notify_valid          (notify_valid),
    .notify_ready          (notify_ready),
    .axis_host_recv_tdata  (recv_tdata),
    .axis_host_recv_tkeep  (recv_tkeep),
    .axis_host_recv_tlast  (recv_tlast),
    .axis_host_recv_tid    (recv_tid),
    .axis_host_recv_tvalid (recv_tvalid),
    .axis_host_recv_tready (recv_tready),
    .axis_host_send_tdata  (send_tdata),
    .axis_host_send_tkeep  (send_tkeep),
    .axis_host_send_tlast  (send_tlast),
    .axis_host_send_tid    (send_tid),
    .axis_host_send_tvalid (send_tvalid),
    .axis_host_send_tready (send_tready)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic axil_write(input logic [15:0] addr, input logic [63:0] data, input logic [7:0] strb);
    int unsigned n;
    n = 0;
    s_axil_awaddr  = addr;
    s_axil_wdata   = data;
    s_axil_wstrb   = strb;
    s_axil_awvalid = 1'b1;
    s_axil_wvalid  = 1'b1;
    while (!(s_axil_awready && s_axil_wready) && n < 20) begin
      tick();
      n++;
    end
    check("axil_aw_wait", n < 20, 1'b1);
    tick();
    s_axil_awvalid = 1'b0;
    s_axil_wvalid  = 1'b0;
    check("axil_bresp", {s_axil_bvalid, s_axil_bresp, s_axil_awready}, {1'b1, 2'b00, 1'b0});
    tick();
  endtask

  task automatic axil_read_check(input string tag, input logic [15:0] addr, input logic [63:0] exp);
    int unsigned n;
    n = 0;
    s_axil_araddr  = addr;
    s_axil_arvalid = 1'b1;
    while (!s_axil_arready && n < 20) begin
      tick();
      n++;
    end
    tick();
    s_axil_arvalid = 1'b0;
    check(tag, {s_axil_rvalid, s_axil_rresp, s_axil_rdata}, {1'b1, 2'b00, exp});
    tick();
  endtask

  req_t        exp_rd;
  req_t        exp_wr;
  logic [31:0] in_lane0  [4];
  logic [31:0] exp_lane0 [4];
  int unsigned in_idx;
  int unsigned out_idx;
  int unsigned n_notify;
  logic        stable_ok;

  initial begin
    n_assert = 0;
    n_fail   = 0;
    areset = 1'b1;
    s_axil_awaddr = '0; s_axil_awvalid = 1'b0; s_axil_wdata = '0; s_axil_wstrb = '0; s_axil_wvalid = 1'b0;
    s_axil_bready = 1'b1; s_axil_araddr = '0; s_axil_arvalid = 1'b0; s_axil_rready = 1'b1;
    sq_rd_ready = 1'b0; sq_wr_ready = 1'b0;
    cq_rd_data = '0; cq_rd_valid = 1'b0; cq_wr_data = '0; cq_wr_valid = 1'b0;
    notify_ready = 1'b0;
    recv_tdata = '0; recv_tkeep = '0; recv_tlast = 1'b0; recv_tid = '0; recv_tvalid = 1'b0;
    send_tready = 1'b1;

    // Reset state
    repeat (5) tick();
    check("rst_valids", {sq_rd_valid, sq_wr_valid, notify_valid, s_axil_bvalid, s_axil_rvalid, send_tvalid}, 6'b0);
    check("rst_readies", {s_axil_awready, s_axil_wready, s_axil_arready, cq_rd_ready, cq_wr_ready, recv_tready}, 6'b111001);
    areset = 1'b0;
    tick();
    axil_read_check("rst_status", 16'h08, 64'h0);
    axil_read_check("rst_done_cnt", 16'h28, 64'h0);

    // Job 1: both acks in the same cycle
    axil_write(16'h10, 64'h1000, 8'hFF);
    axil_write(16'h18, 64'h2000, 8'hFF);
    axil_write(16'h20, 64'd64, 8'hFF);
    axil_write(16'h38, 64'd3, 8'hFF);
    axil_write(16'h00, 64'h1, 8'hFF);
    exp_rd = '0; exp_rd.opcode = 5'd1; exp_rd.strm = 2'd1; exp_rd.last = 1'b1;
    exp_rd.pid = 6'd3; exp_rd.vaddr = 48'h1000; exp_rd.len = 28'd64;
    exp_wr = exp_rd; exp_wr.opcode = 5'd2; exp_wr.vaddr = 48'h2000;
    check("j1_sq_valid", {sq_rd_valid, sq_wr_valid}, 2'b11);
    check("j1_sq_rd_data", sq_rd_data, exp_rd);
    check("j1_sq_wr_data", sq_wr_data, exp_wr);
    sq_rd_ready = 1'b1; sq_wr_ready = 1'b1;
    tick();
    sq_rd_ready = 1'b0; sq_wr_ready = 1'b0;
    check("j1_wait_cq", {sq_rd_valid, sq_wr_valid, cq_rd_ready, cq_wr_ready, notify_valid}, 5'b00110);
    cq_rd_valid = 1'b1; cq_wr_valid = 1'b1;
    tick();
    cq_rd_valid = 1'b0; cq_wr_valid = 1'b0;
    check("j1_notify", {notify_valid, notify_data}, {1'b1, 6'd3, 32'd1});
    n_notify = 0;
    notify_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (notify_valid && notify_ready) n_notify++;
      tick();
    end
    notify_ready = 1'b0;
    check("j1_notify_count", n_notify, 1);
    axil_read_check("j1_status", 16'h08, 64'h2);
    axil_read_check("j1_done_cnt", 16'h28, 64'h1);
    axil_read_check("j1_ctrl_selfclr", 16'h00, 64'h0);

    // Job 2: write side stalled 10 cycles, acks wr-then-rd with a duplicate
    axil_write(16'h00, 64'h1, 8'hFF);
    sq_rd_ready = 1'b1;
    tick();
    sq_rd_ready = 1'b0;
    stable_ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (sq_rd_valid || !sq_wr_valid || sq_wr_data !== exp_wr || cq_wr_ready || notify_valid) stable_ok = 1'b0;
      tick();
    end
    check("j2_wr_stall_stable", stable_ok, 1'b1);
    sq_wr_ready = 1'b1;
    tick();
    sq_wr_ready = 1'b0;
    cq_wr_valid = 1'b1;
    tick();
    tick();
    cq_wr_valid = 1'b0;
    check("j2_no_notify_wr_only", {notify_valid, cq_rd_ready}, 2'b01);
    cq_rd_valid = 1'b1;
    tick();
    cq_rd_valid = 1'b0;
    check("j2_notify", {notify_valid, notify_data}, {1'b1, 6'd3, 32'd2});
    n_notify = 0;
    notify_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (notify_valid && notify_ready) n_notify++;
      tick();
    end
    notify_ready = 1'b0;
    check("j2_notify_count", n_notify, 1);
    axil_read_check("j2_done_cnt", 16'h28, 64'h2);

    // Stream path: INCR=5, send_tready toggling
    axil_write(16'h30, 64'h5, 8'hFF);
    in_lane0[0] = 32'd0; in_lane0[1] = 32'd1; in_lane0[2] = 32'd2; in_lane0[3] = 32'hFFFF_FFFE;
    exp_lane0[0] = 32'd5; exp_lane0[1] = 32'd6; exp_lane0[2] = 32'd7; exp_lane0[3] = 32'd3;
    in_idx = 0;
    out_idx = 0;
    for (int cyc = 0; cyc < 40 && out_idx < 4; cyc++) begin
      send_tready = (cyc % 2 == 0);
      if (in_idx < 4) begin
        recv_tvalid = 1'b1;
        recv_tdata = '0;
        recv_tdata[31:0] = in_lane0[in_idx];
        recv_tdata[511:480] = 32'hFFFF_FFFB + 32'(in_idx);
        recv_tkeep = (in_idx == 3) ? 64'h0000_0000_0000_FFFF : {64{1'b1}};
        recv_tlast = (in_idx == 3);
        recv_tid = 6'(in_idx + 1);
      end else begin
        recv_tvalid = 1'b0;
      end
      #1;
      if (send_tvalid && send_tready) begin
        check("stream_beat", {send_tlast, send_tid, send_tkeep, send_tdata[511:480], send_tdata[31:0]},
              {(out_idx == 3), 6'(out_idx + 1), (out_idx == 3) ? 64'h0000_0000_0000_FFFF : {64{1'b1}},
               32'(out_idx), exp_lane0[out_idx]});
        out_idx++;
      end
      if (recv_tvalid && recv_tready) in_idx++;
      @(posedge aclk);
      #1;
    end
    recv_tvalid = 1'b0;
    send_tready = 1'b1;
    check("stream_beat_counts", {8'(in_idx), 8'(out_idx)}, {8'd4, 8'd4});
    tick();
    check("stream_drained", send_tvalid, 1'b0);

    // Job 3: extra START while busy is ignored
    axil_write(16'h00, 64'h1, 8'hFF);
    axil_write(16'h00, 64'h1, 8'hFF);
    sq_rd_ready = 1'b1; sq_wr_ready = 1'b1;
    tick();
    sq_rd_ready = 1'b0; sq_wr_ready = 1'b0;
    cq_rd_valid = 1'b1; cq_wr_valid = 1'b1;
    tick();
    cq_rd_valid = 1'b0; cq_wr_valid = 1'b0;
    check("j3_notify", {notify_valid, notify_data}, {1'b1, 6'd3, 32'd3});
    notify_ready = 1'b1;
    tick();
    notify_ready = 1'b0;
    stable_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (sq_rd_valid || sq_wr_valid || notify_valid) stable_ok = 1'b0;
      tick();
    end
    check("j3_busy_start_ignored", stable_ok, 1'b1);
    axil_read_check("j3_done_cnt", 16'h28, 64'h3);

    // Strobes, field widths, unmapped and read-only addresses
    axil_write(16'h10, 64'hFFFF_FFFF_FFFF_FF55, 8'h01);
    axil_read_check("strb_rd_vaddr", 16'h10, 64'h1055);
    axil_write(16'h20, {64{1'b1}}, 8'hFF);
    axil_read_check("len_width", 16'h20, 64'h0FFF_FFFF);
    axil_write(16'h40, 64'hDEAD, 8'hFF);
    axil_read_check("unmapped", 16'h40, 64'h0);
    axil_write(16'h08, 64'hFF, 8'hFF);
    axil_read_check("status_ro", 16'h08, 64'h2);

    // Job 4: reset while waiting for completions
    axil_write(16'h00, 64'h1, 8'hFF);
    sq_rd_ready = 1'b1; sq_wr_ready = 1'b1;
    tick();
    sq_rd_ready = 1'b0; sq_wr_ready = 1'b0;
    axil_read_check("j4_status_busy", 16'h08, 64'h1);
    check("j4_in_wait_cq", {cq_rd_ready, cq_wr_ready}, 2'b11);
    areset = 1'b1;
    tick();
    areset = 1'b0;
    check("mid_rst_valids", {sq_rd_valid, sq_wr_valid, cq_rd_ready, cq_wr_ready, notify_valid, send_tvalid}, 6'b0);
    check("mid_rst_readies", {s_axil_awready, s_axil_arready, recv_tready}, 3'b111);
    cq_rd_valid = 1'b1; cq_wr_valid = 1'b1;
    tick();
    cq_rd_valid = 1'b0; cq_wr_valid = 1'b0;
    tick();
    check("post_rst_ack_ignored", {notify_valid, cq_rd_ready, sq_rd_valid}, 3'b000);
    axil_read_check("post_rst_status", 16'h08, 64'h0);
    axil_read_check("post_rst_done_cnt", 16'h28, 64'h0);
    axil_read_check("post_rst_rd_vaddr", 16'h10, 64'h0);
    axil_read_check("post_rst_len", 16'h20, 64'h0);
    axil_read_check("post_rst_incr", 16'h30, 64'h0);
    axil_read_check("post_rst_pid", 16'h38, 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
